// File: rtl/preload_loader.sv
// Assembles MSB-first host bytes into words and writes them to program memory; flag is 1 cycle after the 4th byte.
// Byte ready drops during the write cycle and stays low once loading finishes (run) or memory overflows (error).
module preload_loader #(
    parameter int               LEN               = 32,
    parameter int               NB_BYTE           = 8,
    parameter int               RAM_DEPTH_PROGRAM = 32,
    parameter int               NB_COUNT          = 6,
    parameter logic [LEN-1:0]   HALT_WORD         = 32'hffffffff,
    parameter int               TIMEOUT_CYCLES    = 1000,
    parameter int               NB_TIMEOUT        = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_byte_valid,
    input  logic [NB_BYTE-1:0]  i_byte,
    output logic                o_byte_ready,
    output logic                o_preload_flag,
    output logic [LEN-1:0]      o_preload_address,
    output logic [LEN-1:0]      o_preload_instruction,
    output logic                o_run,
    output logic                o_error,
    output logic                o_timeout,
    output logic [NB_COUNT-1:0] o_word_count
);

    localparam int NB_BYTES = LEN / NB_BYTE;
    localparam int NB_BCNT  = $clog2(NB_BYTES + 1);

    localparam logic [NB_BCNT-1:0]    LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [LEN-1:0]        LAST_ADDR = LEN'(RAM_DEPTH_PROGRAM - 1);
    // The counter fires on the edge where it would step onto TIMEOUT_CYCLES-1.
    localparam logic [NB_TIMEOUT-1:0] TO_FIRE   = NB_TIMEOUT'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {LOAD, WRITE, DONE, ERROR} state_t;

    state_t                state;
    logic [NB_BCNT-1:0]    byte_cnt;
    logic [LEN-1:0]        addr;
    logic [LEN-1:0]        word;
    logic [NB_TIMEOUT-1:0] timeout_cnt;
    logic                  accept;
    logic [LEN-1:0]        next_word;

    assign accept    = i_byte_valid && o_byte_ready && (state == LOAD);
    assign next_word = {word[LEN-NB_BYTE-1:0], i_byte};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state                 <= LOAD;
            byte_cnt              <= '0;
            addr                  <= '0;
            word                  <= '0;
            timeout_cnt           <= '0;
            o_byte_ready          <= 1'b1;
            o_preload_flag        <= 1'b0;
            o_preload_address     <= '0;
            o_preload_instruction <= '0;
            o_run                 <= 1'b0;
            o_error               <= 1'b0;
            o_timeout             <= 1'b0;
            o_word_count          <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        word        <= next_word;
                        timeout_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt              <= '0;
                            state                 <= WRITE;
                            o_byte_ready          <= 1'b0;
                            o_preload_flag        <= 1'b1;
                            o_preload_address     <= addr;
                            o_preload_instruction <= next_word;
                        end else begin
                            byte_cnt <= byte_cnt + NB_BCNT'(1);
                        end
                    end else if (byte_cnt != '0) begin
                        if (timeout_cnt == TO_FIRE) begin
                            byte_cnt    <= '0;
                            word        <= '0;
                            timeout_cnt <= '0;
                            o_timeout   <= 1'b1;
                        end else begin
                            timeout_cnt <= timeout_cnt + NB_TIMEOUT'(1);
                        end
                    end
                end
                WRITE: begin
                    o_preload_flag <= 1'b0;
                    o_word_count   <= o_word_count + NB_COUNT'(1);
                    // A halt word at the last address still counts as a clean finish.
                    if (word == HALT_WORD) begin
                        state <= DONE;
                        o_run <= 1'b1;
                    end else if (addr == LAST_ADDR) begin
                        state   <= ERROR;
                        o_error <= 1'b1;
                    end else begin
                        addr         <= addr + LEN'(1);
                        state        <= LOAD;
                        o_byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preload_loader.sv
module tb_preload_loader;

    logic        i_clk        = 1'b0;
    logic        i_rst        = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte       = 8'h00;
    logic        o_byte_ready;
    logic        o_preload_flag;
    logic [31:0] o_preload_address;
    logic [31:0] o_preload_instruction;
    logic        o_run;
    logic        o_error;
    logic        o_timeout;
    logic [2:0]  o_word_count;

    int          total = 0;
    int          bad   = 0;
    int          acc   = 0;
    logic [63:0] wq[$];

    preload_loader #(
        .LEN(32), .NB_BYTE(8), .RAM_DEPTH_PROGRAM(4), .NB_COUNT(3),
        .HALT_WORD(32'hffffffff), .TIMEOUT_CYCLES(8), .NB_TIMEOUT(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_byte_valid(i_byte_valid),
        .i_byte(i_byte),
        .o_byte_ready(o_byte_ready),
        .o_preload_flag(o_preload_flag),
        .o_preload_address(o_preload_address),
        .o_preload_instruction(o_preload_instruction),
        .o_run(o_run),
        .o_error(o_error),
        .o_timeout(o_timeout),
        .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge, so at negedge they are stable for the next edge.
    always @(negedge i_clk) begin
        if (i_rst && i_byte_valid && o_byte_ready) acc++;
        if (o_preload_flag) begin
            wq.push_back({o_preload_address, o_preload_instruction});
            check("ready_low_in_write", {63'd0, o_byte_ready}, 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        i_byte_valid = 1'b1;
        i_byte = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_byte_ready) begin
                @(posedge i_clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        check("byte_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic idle(input int n);
        i_byte_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {63'd0, o_byte_ready}, 64'd1);
        check({tag, "_flag"},  {63'd0, o_preload_flag}, 64'd0);
        check({tag, "_addr"},  {32'd0, o_preload_address}, 64'd0);
        check({tag, "_instr"}, {32'd0, o_preload_instruction}, 64'd0);
        check({tag, "_run"},   {63'd0, o_run}, 64'd0);
        check({tag, "_error"}, {63'd0, o_error}, 64'd0);
        check({tag, "_tmo"},   {63'd0, o_timeout}, 64'd0);
        check({tag, "_wc"},    {61'd0, o_word_count}, 64'd0);
    endtask

    task automatic release_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        wq.delete();
        acc = 0;
    endtask

    task automatic reset_dut();
        i_byte_valid = 1'b0;
        i_rst = 1'b0;
        #2;
        release_reset();
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] w);
        if (idx < wq.size()) check(tag, wq[idx], {a, w});
        else check({tag, "_missing"}, 64'(wq.size()), 64'(idx + 1));
    endtask

    initial begin
        int pulses;
        int at;
        int a0;

        // Power-on reset values
        #12;
        check_reset_vals("por");
        release_reset();

        // Three words back-to-back with valid held high the whole time
        send_word(32'h20010005);
        send_word(32'h20020007);
        send_word(32'hffffffff);
        idle(3);
        check("t1_nwrites", 64'(wq.size()), 64'd3);
        check_wr("t1_w0", 0, 32'd0, 32'h20010005);
        check_wr("t1_w1", 1, 32'd1, 32'h20020007);
        check_wr("t1_w2", 2, 32'd2, 32'hffffffff);
        check("t1_run",   {63'd0, o_run}, 64'd1);
        check("t1_error", {63'd0, o_error}, 64'd0);
        check("t1_wc",    {61'd0, o_word_count}, 64'd3);
        check("t1_ready", {63'd0, o_byte_ready}, 64'd0);
        check("t1_accepts", 64'(acc), 64'd12);
        check("t1_addr_hold",  {32'd0, o_preload_address}, 64'd2);
        check("t1_instr_hold", {32'd0, o_preload_instruction}, 64'hffffffff);

        // Reset while running drops run without waiting for a clock edge
        i_rst = 1'b0;
        #1;
        check("t1_run_async_drop", {63'd0, o_run}, 64'd0);
        #1;
        check_reset_vals("rst_done");
        release_reset();

        // Partial word discarded after the inter-byte timeout
        send_byte(8'haa);
        send_byte(8'hbb);
        i_byte_valid = 1'b0;
        pulses = 0;
        at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge i_clk);
            #1;
            if (o_timeout) begin
                pulses++;
                at = k;
            end
        end
        check("t3_pulses", 64'(pulses), 64'd1);
        check("t3_pulse_cycle", 64'(at), 64'd7);
        check("t3_no_write", 64'(wq.size()), 64'd0);
        send_word(32'h11223344);
        idle(2);
        check("t3_nwrites", 64'(wq.size()), 64'd1);
        check_wr("t3_w0", 0, 32'd0, 32'h11223344);
        check("t3_wc",    {61'd0, o_word_count}, 64'd1);
        check("t3_ready", {63'd0, o_byte_ready}, 64'd1);

        // Memory fills without a halt word
        reset_dut();
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090a0b0c);
        send_word(32'h0d0e0f10);
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        a0 = acc;
        i_byte = 8'h55;
        repeat (5) begin
            @(posedge i_clk);
            #1;
        end
        i_byte_valid = 1'b0;
        check("t4_accepts", 64'(a0), 64'd16);
        check("t4_refused", 64'(acc), 64'(a0));
        check("t4_nwrites", 64'(wq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) check("t4_addr", {32'd0, wq[i][63:32]}, 64'(i));
        end
        check_wr("t4_w3", 3, 32'd3, 32'h0d0e0f10);
        check("t4_error", {63'd0, o_error}, 64'd1);
        check("t4_run",   {63'd0, o_run}, 64'd0);
        check("t4_ready", {63'd0, o_byte_ready}, 64'd0);
        check("t4_wc",    {61'd0, o_word_count}, 64'd4);

        // Halt word at the last address finishes cleanly
        reset_dut();
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090a0b0c);
        send_word(32'hffffffff);
        idle(3);
        check_wr("t4b_w3", 3, 32'd3, 32'hffffffff);
        check("t4b_run",   {63'd0, o_run}, 64'd1);
        check("t4b_error", {63'd0, o_error}, 64'd0);
        check("t4b_wc",    {61'd0, o_word_count}, 64'd4);

        // Reset in the middle of word 1 loses the partial word and restarts at address 0
        reset_dut();
        send_word(32'ha1b2c3d4);
        send_byte(8'h12);
        send_byte(8'h34);
        i_byte_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        check_reset_vals("t5_mid");
        release_reset();
        send_word(32'hcafef00d);
        send_word(32'hffffffff);
        idle(3);
        check("t5_nwrites", 64'(wq.size()), 64'd2);
        check_wr("t5_w0", 0, 32'd0, 32'hcafef00d);
        check_wr("t5_w1", 1, 32'd1, 32'hffffffff);
        check("t5_wc", {61'd0, o_word_count}, 64'd2);

        // Halt as the very first word
        reset_dut();
        send_word(32'hffffffff);
        idle(3);
        check("t6_nwrites", 64'(wq.size()), 64'd1);
        check_wr("t6_w0", 0, 32'd0, 32'hffffffff);
        check("t6_run",  {63'd0, o_run}, 64'd1);
        check("t6_wc",   {61'd0, o_word_count}, 64'd1);
        check("t6_flag", {63'd0, o_preload_flag}, 64'd0);
        check("t6_addr_hold",  {32'd0, o_preload_address}, 64'd0);
        check("t6_instr_hold", {32'd0, o_preload_instruction}, 64'hffffffff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
